grid_cursor: RTL

Synchronous, parametrised cursor controller for the crossword grid. It turns keyboard keycodes into a highlighted cell position with one step per key press. A held arrow key auto-repeats after a delay. Also provides across/down entry-direction toggle, optional edge wrap, and auto-advance after a letter is written. Sits between the USB keycode source and the VGA colour mapper; highlightX/highlightY drive the highlight box.

---
 rtl/grid_cursor.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/grid_cursor.sv
// grid_cursor: keycode-driven cursor for the crossword grid.
// Arrow keys step the cursor (with auto-repeat while held), 8'h2C toggles the
// entry direction and letter_wr advances one cell in the entry direction.
// Optional feature macro: GRID_CURSOR_SKIP_EN adds block_mask so steps skip
// over black cells; without it every cell is open.
module grid_cursor #(
  parameter int unsigned COLS        = 5,
  parameter int unsigned ROWS        = 5,
  parameter int unsigned CELL_W      = 80,
  parameter int unsigned CELL_H      = 80,
  parameter int unsigned ORIGIN_X    = 3,
  parameter int unsigned ORIGIN_Y    = 80,
  parameter int unsigned REPEAT_DLY  = 30,
  parameter int unsigned REPEAT_RATE = 6,
  parameter int unsigned WRAP        = 0
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic                      frame_tick,
  input  logic [7:0]                keycode,
  input  logic                      letter_wr,
`ifdef GRID_CURSOR_SKIP_EN
  input  logic [COLS*ROWS-1:0]      block_mask,
`endif
  output logic [$clog2(COLS)-1:0]   cell_col,
  output logic [$clog2(ROWS)-1:0]   cell_row,
  output logic [9:0]                highlightX,
  output logic [9:0]                highlightY,
  output logic                      dir_down,
  output logic                      moved
);

  localparam int unsigned CW    = $clog2(COLS);
  localparam int unsigned RW    = $clog2(ROWS);
  localparam int unsigned NCELL = COLS * ROWS;
  localparam int unsigned IW    = $clog2(NCELL);
  localparam int unsigned CNT_W = $clog2(REPEAT_DLY + REPEAT_RATE + 1);
  localparam int          NC    = int'(COLS);
  localparam int          NR    = int'(ROWS);

  localparam logic [CNT_W-1:0] DLY_LAST  = CNT_W'(REPEAT_DLY - 1);
  localparam logic [CNT_W-1:0] RATE_LAST = CNT_W'(REPEAT_RATE - 1);

  localparam logic [7:0] KEY_RIGHT  = 8'h4F;
  localparam logic [7:0] KEY_LEFT   = 8'h50;
  localparam logic [7:0] KEY_DOWN   = 8'h51;
  localparam logic [7:0] KEY_UP     = 8'h52;
  localparam logic [7:0] KEY_TOGGLE = 8'h2C;

  localparam logic [1:0] DIR_R = 2'd0;
  localparam logic [1:0] DIR_L = 2'd1;
  localparam logic [1:0] DIR_D = 2'd2;
  localparam logic [1:0] DIR_U = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_HELD   = 2'd1,
    S_REPEAT = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       prev_key_q, prev_key_d;
  logic [CW-1:0]    col_q, col_d;
  logic [RW-1:0]    row_q, row_d;
  logic             dir_q, dir_d;
  logic             moved_q, moved_d;

  logic             is_arrow, is_toggle, key_edge;
  logic [1:0]       key_dir;
  logic             arrow_step;
  logic             step_req;
  logic [1:0]       step_dir;
  logic             step_ok;
  logic [CW-1:0]    step_col;
  logic [RW-1:0]    step_row;
  logic [NCELL-1:0] blk;
  int               p;

`ifdef GRID_CURSOR_SKIP_EN
  assign blk = block_mask;
`else
  assign blk = '0;
`endif

  // Decode the current keycode into class and step direction.
  always_comb begin
    is_arrow  = 1'b0;
    is_toggle = (keycode == KEY_TOGGLE);
    key_dir   = DIR_R;
    case (keycode)
      KEY_RIGHT: begin is_arrow = 1'b1; key_dir = DIR_R; end
      KEY_LEFT:  begin is_arrow = 1'b1; key_dir = DIR_L; end
      KEY_DOWN:  begin is_arrow = 1'b1; key_dir = DIR_D; end
      KEY_UP:    begin is_arrow = 1'b1; key_dir = DIR_U; end
      default:   ;
    endcase
    key_edge = (keycode != prev_key_q);
  end

  // Key-hold FSM: press step, delay, then periodic repeat; toggle flips direction.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dir_d      = dir_q;
    arrow_step = 1'b0;
    if (is_toggle) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      if (key_edge) dir_d = ~dir_q;
    end else if (!is_arrow) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else if (key_edge) begin
      arrow_step = 1'b1;
      state_d    = S_HELD;
      cnt_d      = '0;
    end else begin
      case (state_q)
        S_HELD: begin
          if (frame_tick) begin
            if (cnt_q == DLY_LAST) begin
              arrow_step = 1'b1;
              cnt_d      = '0;
              state_d    = S_REPEAT;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        S_REPEAT: begin
          if (frame_tick) begin
            if (cnt_q == RATE_LAST) begin
              arrow_step = 1'b1;
              cnt_d      = '0;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Arrow step has priority; otherwise a letter write advances along dir_down.
  always_comb begin
    step_req = arrow_step | letter_wr;
    if (arrow_step) step_dir = key_dir;
    else            step_dir = dir_q ? DIR_D : DIR_R;
  end

  // Find the nearest open cell in the step direction, honouring wrap/clamp.
  always_comb begin
    step_ok  = 1'b0;
    step_col = col_q;
    step_row = row_q;
    p        = 0;
    if (step_req) begin
      if (step_dir == DIR_R || step_dir == DIR_L) begin
        for (int k = 1; k < NC; k++) begin
          p = (step_dir == DIR_L) ? int'(col_q) - k : int'(col_q) + k;
          if (WRAP != 0) begin
            if (p < 0)        p = p + NC;
            else if (p >= NC) p = p - NC;
          end
          if (!step_ok && p >= 0 && p < NC) begin
            if (!blk[IW'(int'(row_q) * NC + p)]) begin
              step_ok  = 1'b1;
              step_col = CW'(p);
            end
          end
        end
      end else begin
        for (int k = 1; k < NR; k++) begin
          p = (step_dir == DIR_U) ? int'(row_q) - k : int'(row_q) + k;
          if (WRAP != 0) begin
            if (p < 0)        p = p + NR;
            else if (p >= NR) p = p - NR;
          end
          if (!step_ok && p >= 0 && p < NR) begin
            if (!blk[IW'(p * NC + int'(col_q))]) begin
              step_ok  = 1'b1;
              step_row = RW'(p);
            end
          end
        end
      end
    end
  end

  // Next position, move pulse and key history.
  always_comb begin
    col_d      = col_q;
    row_d      = row_q;
    moved_d    = 1'b0;
    prev_key_d = keycode;
    if (step_ok) begin
      col_d   = step_col;
      row_d   = step_row;
      moved_d = 1'b1;
    end
  end

  // State and output registers.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      prev_key_q <= '0;
      col_q      <= '0;
      row_q      <= '0;
      dir_q      <= 1'b0;
      moved_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      prev_key_q <= prev_key_d;
      col_q      <= col_d;
      row_q      <= row_d;
      dir_q      <= dir_d;
      moved_q    <= moved_d;
    end
  end

  assign cell_col   = col_q;
  assign cell_row   = row_q;
  assign dir_down   = dir_q;
  assign moved      = moved_q;
  assign highlightX = 10'(ORIGIN_X) + 10'(col_q) * 10'(CELL_W);
  assign highlightY = 10'(ORIGIN_Y) + 10'(row_q) * 10'(CELL_H);

endmodule
